// File: rtl/ternary_cam_seq_if.sv
// Bus bundle for ternary_cam_seq: write/invalidate port, search request and search results.
//  master: write/invalidate/search requester (drives requests, observes results)
//  slave : the CAM itself
interface ternary_cam_seq_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3
);
  logic                  Writ_Enable;
  logic [ADDR_WIDTH-1:0] WR_Addr;
  logic [DATA_WIDTH-1:0] Data_IN;
  logic                  Invalidate;
  logic                  Search_Start;
  logic [DATA_WIDTH-1:0] CMP_Din;
  logic [DATA_WIDTH-1:0] CMP_Mask;
  logic                  Busy;
  logic                  Done;
  logic                  Match;
  logic [ADDR_WIDTH-1:0] Match_Addr;
  logic [ADDR_WIDTH:0]   Match_Count;
  logic                  Multi_Match;

  modport master (
    output Writ_Enable, WR_Addr, Data_IN, Invalidate, Search_Start, CMP_Din, CMP_Mask,
    input  Busy, Done, Match, Match_Addr, Match_Count, Multi_Match
  );

  modport slave (
    input  Writ_Enable, WR_Addr, Data_IN, Invalidate, Search_Start, CMP_Din, CMP_Mask,
    output Busy, Done, Match, Match_Addr, Match_Count, Multi_Match
  );
endinterface

// File: rtl/ternary_cam_seq.sv
// Ternary CAM with sequential search: SEARCH_PAR entries compared per cycle.
// Ports:
//  Clk  - rising-edge clock
//  Rest - asynchronous active-low reset
//  bus  - ternary_cam_seq_if slave: write/invalidate, search request, registered results
//         (Busy, Done, Match, Match_Addr, Match_Count, Multi_Match)
module ternary_cam_seq #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned SEARCH_PAR = 2
) (
  input  logic             Clk,
  input  logic             Rest,
  ternary_cam_seq_if.slave bus
);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned N     = DEPTH / SEARCH_PAR;
  localparam int unsigned SW    = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]      r_valid;
  logic [DATA_WIDTH-1:0] r_key, w_key_nxt, r_mask, w_mask_nxt;
  logic [SW-1:0]         r_slice, w_slice_nxt;
  logic [CW-1:0]         r_acc_cnt, w_acc_cnt_nxt;
  logic                  r_acc_found, w_acc_found_nxt;
  logic [ADDR_WIDTH-1:0] r_acc_addr, w_acc_addr_nxt;
  logic                  r_busy, w_busy_nxt, r_done, w_done_nxt;
  logic                  r_match, w_match_nxt, r_multi, w_multi_nxt;
  logic [ADDR_WIDTH-1:0] r_match_addr, w_match_addr_nxt;
  logic [CW-1:0]         r_match_cnt, w_match_cnt_nxt;

  logic                  w_wr_en, w_inv_en;
  logic [ADDR_WIDTH-1:0] w_idx, w_slice_addr;
  logic                  w_slice_hit;
  logic [CW-1:0]         w_slice_cnt, w_sum;
  logic                  w_found_upd;
  logic [ADDR_WIDTH-1:0] w_addr_upd;

  // Array updates are accepted only while idle; write beats invalidate.
  assign w_wr_en  = (r_state == S_IDLE) && bus.Writ_Enable;
  assign w_inv_en = (r_state == S_IDLE) && bus.Invalidate && !bus.Writ_Enable;

  // Data array carries no reset; the valid bits gate every use of it.
  always_ff @(posedge Clk) begin
    if (w_wr_en) r_mem[bus.WR_Addr] <= bus.Data_IN;
  end

  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      r_valid <= '0;
    end else if (w_wr_en) begin
      r_valid[bus.WR_Addr] <= 1'b1;
    end else if (w_inv_en) begin
      r_valid[bus.WR_Addr] <= 1'b0;
    end
  end

  // Compare the current slice; walking downwards leaves the lowest hit in w_slice_addr.
  always_comb begin
    w_slice_hit  = 1'b0;
    w_slice_addr = '0;
    w_slice_cnt  = '0;
    w_idx        = '0;
    for (int j = int'(SEARCH_PAR) - 1; j >= 0; j--) begin
      w_idx = ADDR_WIDTH'(int'(r_slice) * int'(SEARCH_PAR) + j);
      if (r_valid[w_idx] && (((r_mem[w_idx] ^ r_key) & r_mask) == '0)) begin
        w_slice_hit  = 1'b1;
        w_slice_addr = w_idx;
        w_slice_cnt  = w_slice_cnt + CW'(1);
      end
    end
  end

  // Running totals including the current slice; first match is kept once found.
  assign w_sum       = r_acc_cnt + w_slice_cnt;
  assign w_found_upd = r_acc_found || w_slice_hit;
  assign w_addr_upd  = r_acc_found ? r_acc_addr : w_slice_addr;

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_key_nxt        = r_key;
    w_mask_nxt       = r_mask;
    w_slice_nxt      = r_slice;
    w_acc_cnt_nxt    = r_acc_cnt;
    w_acc_found_nxt  = r_acc_found;
    w_acc_addr_nxt   = r_acc_addr;
    w_busy_nxt       = r_busy;
    w_done_nxt       = 1'b0;
    w_match_nxt      = r_match;
    w_match_addr_nxt = r_match_addr;
    w_match_cnt_nxt  = r_match_cnt;
    w_multi_nxt      = r_multi;
    case (r_state)
      S_IDLE: begin
        if (bus.Search_Start) begin
          w_state_nxt      = S_SEARCH;
          w_key_nxt        = bus.CMP_Din;
          w_mask_nxt       = bus.CMP_Mask;
          w_slice_nxt      = '0;
          w_acc_cnt_nxt    = '0;
          w_acc_found_nxt  = 1'b0;
          w_acc_addr_nxt   = '0;
          w_busy_nxt       = 1'b1;
          w_match_nxt      = 1'b0;
          w_match_addr_nxt = '0;
          w_match_cnt_nxt  = '0;
          w_multi_nxt      = 1'b0;
        end
      end
      S_SEARCH: begin
        w_acc_cnt_nxt   = w_sum;
        w_acc_found_nxt = w_found_upd;
        w_acc_addr_nxt  = w_addr_upd;
        w_slice_nxt     = r_slice + SW'(1);
        if (r_slice == SW'(N - 1)) begin
          w_state_nxt      = S_DONE;
          w_done_nxt       = 1'b1;
          w_match_nxt      = w_found_upd;
          w_match_addr_nxt = w_addr_upd;
          w_match_cnt_nxt  = w_sum;
          w_multi_nxt      = (w_sum > CW'(1));
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and result registers.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      r_state      <= S_IDLE;
      r_key        <= '0;
      r_mask       <= '0;
      r_slice      <= '0;
      r_acc_cnt    <= '0;
      r_acc_found  <= 1'b0;
      r_acc_addr   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_match      <= 1'b0;
      r_match_addr <= '0;
      r_match_cnt  <= '0;
      r_multi      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_key        <= w_key_nxt;
      r_mask       <= w_mask_nxt;
      r_slice      <= w_slice_nxt;
      r_acc_cnt    <= w_acc_cnt_nxt;
      r_acc_found  <= w_acc_found_nxt;
      r_acc_addr   <= w_acc_addr_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_match      <= w_match_nxt;
      r_match_addr <= w_match_addr_nxt;
      r_match_cnt  <= w_match_cnt_nxt;
      r_multi      <= w_multi_nxt;
    end
  end

  assign bus.Busy        = r_busy;
  assign bus.Done        = r_done;
  assign bus.Match       = r_match;
  assign bus.Match_Addr  = r_match_addr;
  assign bus.Match_Count = r_match_cnt;
  assign bus.Multi_Match = r_multi;
endmodule
